hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter MAX_LONG, default 4: maximum outstanding long-latency writes.
REQ-002 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-003 SHALL provide: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide: id_valid  input  1  valid instruction in ID.
REQ-005 SHALL provide: id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  ID register addresses.
REQ-006 SHALL provide: id_uses_rs1, id_uses_rs2, id_regWrite, id_is_long  input  1 each  ID decode flags.
REQ-007 SHALL provide: ex_memRead  input  1; ex_rd  input  5  load in EX and its destination.
REQ-008 SHALL provide: long_done  input  1; long_rd  input  5  long-op writeback strobe and destination.
REQ-009 SHALL provide: branch_taken  input  1  taken branch or jump resolved in EX.
REQ-010 SHALL provide: pc_write, if_id_write, if_id_flush, id_ex_flush  output  1 each  pipeline controls.
REQ-011 SHALL provide: hz_state  output  2  current state (00 RUN, 01 LOAD_BUBBLE, 10 LONG_WAIT).
REQ-012 SHALL provide: pend_mask  output  32  registered scoreboard, bit 0 always 0.
REQ-013 SHALL provide: stall_count  output  32  stall statistics (see Configuration).

Function
REQ-014 SHALL treat register x0 as never pending, never matched, never set.
REQ-015 SHALL define eff_pend = pend_mask with bit long_rd cleared when long_done is asserted (same-cycle bypass).
REQ-016 SHALL raise load_hz when id_valid, ex_memRead, ex_rd!=0, and ex_rd equals a used rs (uses flag set).
REQ-017 SHALL raise long_hz when id_valid and: a used rs is set in eff_pend, or id_regWrite with id_rd_addr set in eff_pend (WAW), or id_is_long with outstanding count == MAX_LONG.
REQ-018 SHALL compute stall = (load_hz | long_hz) & ~branch_taken.
REQ-019 SHALL drive pc_write = if_id_write = ~stall, id_ex_flush = stall | branch_taken, if_id_flush = branch_taken; all combinational, no added latency.
REQ-020 SHALL accept a long issue when id_valid, id_is_long, ~stall, ~branch_taken; set pend_mask[id_rd_addr] at the next edge if id_regWrite and rd!=0; increment outstanding.
REQ-021 SHALL clear pend_mask[long_rd] and decrement outstanding at the next edge on long_done; when set and clear hit the same register in one cycle, the set SHALL win; counter nets to unchanged.
REQ-022 SHALL saturate outstanding at 0 and MAX_LONG; long_done with outstanding==0 SHALL be ignored.
REQ-023 SHALL register next state each cycle: branch_taken -> RUN; else long_hz -> LONG_WAIT; else load_hz -> LOAD_BUBBLE; else RUN (long_hz has priority over load_hz).
REQ-024 SHALL leave scoreboard unchanged by branch_taken (in-flight long ops still complete).

Reset
REQ-025 SHALL on rst asynchronously clear pend_mask, outstanding, stall_count, and set hz_state = RUN.
REQ-026 SHALL drive outputs during reset from cleared state: pc_write=1, if_id_write=1, flushes follow branch_taken only.
REQ-027 SHALL discard any long op in flight when reset asserts mid-operation; a later long_done SHALL be ignored per REQ-022.

Configuration
REQ-028 SHALL, with HAZARD_STATS_EN defined, increment stall_count by 1 each cycle stall=1, wrapping 0xFFFFFFFF -> 0.
REQ-029 SHALL, without HAZARD_STATS_EN, tie stall_count to 0 and omit the counter register.

Verification
REQ-030 Load x5 in EX, ID uses rs1=x5 -> one cycle pc_write=0, id_ex_flush=1, hz_state=01 next; then RUN.
REQ-031 Long issue rd=x7, dependent rs2=x7 follows -> stall until long_done long_rd=7; released the same cycle; pend_mask 0x80 -> 0.
REQ-032 Four long issues x1..x4 outstanding, fifth long op -> stall, hz_state=10; one long_done -> fifth issues next cycle.
REQ-033 Stall pending plus branch_taken=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, hz_state=00, pend_mask unchanged.
REQ-034 Issue rd=x9 and long_done long_rd=9 same cycle -> pend_mask[9]=1 afterwards; outstanding unchanged.
REQ-035 rst pulsed mid long op with HAZARD_STATS_EN -> pend_mask=0, stall_count=0 immediately, no edge required.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline hazard unit for an in-order core with a load-use interlock and a
// scoreboard for long-latency (multi-cycle) register writes.
//
// A one-bit-per-register pending mask tracks long ops that have issued and not
// yet written back. An outstanding-op counter caps the number of long ops in
// flight at MAX_LONG. A writeback strobe in the same cycle as a dependent
// instruction releases that instruction immediately (same-cycle bypass).
//
// Parameters
//   MAX_LONG      maximum number of outstanding long-latency writes
//
// Optional feature
//   HAZARD_STATS_EN  when defined, stall_count counts stalled cycles (wraps);
//                    when undefined, stall_count is tied to zero.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   id_valid                     valid instruction in ID
//   id_rs1_addr/id_rs2_addr      ID source registers
//   id_rd_addr                   ID destination register
//   id_uses_rs1/id_uses_rs2      source operands actually read
//   id_regWrite, id_is_long      ID writes rd / is a long-latency op
//   ex_memRead, ex_rd            load in EX and its destination
//   long_done, long_rd           long-op writeback strobe and destination
//   branch_taken                 taken branch/jump resolved in EX
//   pc_write, if_id_write        front-end advance enables
//   if_id_flush, id_ex_flush     pipeline register flushes
//   hz_state                     00 RUN, 01 LOAD_BUBBLE, 10 LONG_WAIT
//   pend_mask                    registered scoreboard, bit 0 always 0
//   stall_count                  stalled-cycle statistics
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int MAX_LONG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_regWrite,
    input  logic        id_is_long,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rd,
    input  logic        long_done,
    input  logic [4:0]  long_rd,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  hz_state,
    output logic [31:0] pend_mask,
    output logic [31:0] stall_count
);

    localparam int CW = $clog2(MAX_LONG + 1);

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        LOAD_BUBBLE = 2'b01,
        LONG_WAIT   = 2'b10
    } hz_state_t;

    hz_state_t      state_q, state_d;
    logic [31:0]    pend_q, pend_d, eff_pend;
    logic [CW-1:0]  outstanding_q, outstanding_d;

    logic done_ok;
    logic at_max;
    logic rs1_live, rs2_live, rd_live;
    logic load_hz, long_hz, stall, long_issue;

    // A writeback with nothing outstanding is stale (e.g. issued before a
    // reset) and is ignored everywhere, including the bypass.
    assign done_ok  = long_done & (outstanding_q != '0);
    assign at_max   = (outstanding_q == CW'(MAX_LONG));

    assign rs1_live = id_uses_rs1 & (id_rs1_addr != 5'd0);
    assign rs2_live = id_uses_rs2 & (id_rs2_addr != 5'd0);
    assign rd_live  = (id_rd_addr != 5'd0);

    // Scoreboard as seen by ID this cycle: a completing writeback is bypassed.
    always_comb begin
        eff_pend = pend_q;
        if (done_ok) begin
            eff_pend[long_rd] = 1'b0;
        end
        eff_pend[0] = 1'b0;
    end

    assign load_hz = id_valid & ex_memRead & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd)));

    assign long_hz = id_valid &
                     ((rs1_live & eff_pend[id_rs1_addr]) |
                      (rs2_live & eff_pend[id_rs2_addr]) |
                      (id_regWrite & rd_live & eff_pend[id_rd_addr]) |
                      (id_is_long & at_max));

    // While reset is held the controls reflect the cleared scoreboard, so no
    // stall is requested regardless of the ID/EX inputs.
    assign stall      = (load_hz | long_hz) & ~branch_taken & ~rst;
    assign long_issue = id_valid & id_is_long & ~stall & ~branch_taken;

    // Clear first, then set: an issue to the register being written back in
    // the same cycle leaves it pending.
    always_comb begin
        pend_d = pend_q;
        if (done_ok) begin
            pend_d[long_rd] = 1'b0;
        end
        if (long_issue & id_regWrite & rd_live) begin
            pend_d[id_rd_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({long_issue, done_ok})
            2'b10: begin
                if (!at_max) begin
                    outstanding_d = outstanding_q + CW'(1);
                end
            end
            2'b01: outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q        <= '0;
            outstanding_q <= '0;
        end else begin
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        if (branch_taken) begin
            state_d = RUN;
        end else if (long_hz) begin
            state_d = LONG_WAIT;
        end else if (load_hz) begin
            state_d = LOAD_BUBBLE;
        end
    end

    always_comb begin
        pc_write    = ~stall;
        if_id_write = ~stall;
        id_ex_flush = stall | branch_taken;
        if_id_flush = branch_taken;
        hz_state    = state_q;
    end

    assign pend_mask = pend_q;

    // ---------------------------------------------------------- statistics
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int MAXL = 4;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_regWrite, id_is_long;
    logic        ex_memRead;
    logic [4:0]  ex_rd;
    logic        long_done;
    logic [4:0]  long_rd;
    logic        branch_taken;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic [1:0]  hz_state;
    logic [31:0] pend_mask;
    logic [31:0] stall_count;

    hazard_scoreboard #(.MAX_LONG(MAXL)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rd_addr   (id_rd_addr),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_regWrite  (id_regWrite),
        .id_is_long   (id_is_long),
        .ex_memRead   (ex_memRead),
        .ex_rd        (ex_rd),
        .long_done    (long_done),
        .long_rd      (long_rd),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .hz_state     (hz_state),
        .pend_mask    (pend_mask),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: set of pending registers, count of ops in flight,
    // last hazard state (0 RUN, 1 load bubble, 2 long wait), stall tally.
    bit          mpend[32];
    int          mout;
    int          mstate;
    logic [31:0] mcount;

    // DUT comb outputs sampled mid-cycle by do_cycle
    logic s_pc, s_exfl, s_iffl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[i] = mpend[i];
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        mout   = 0;
        mstate = 0;
        mcount = '0;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_regWrite = 0; id_is_long = 0;
        ex_memRead = 0; ex_rd = 0; long_done = 0; long_rd = 0; branch_taken = 0;
    endtask

    // Called at posedge+1 with inputs applied; returns at next posedge+1.
    task automatic do_cycle();
        bit eff[32];
        bit dok, ldh, lgh, stl, iss;
        int nxt;
        #3;
        dok = long_done && (mout > 0);
        eff = mpend;
        if (dok) eff[long_rd] = 1'b0;
        ldh = id_valid && ex_memRead && (ex_rd != 0) &&
              ((id_uses_rs1 && id_rs1_addr == ex_rd) || (id_uses_rs2 && id_rs2_addr == ex_rd));
        lgh = id_valid && (
              (id_uses_rs1 && id_rs1_addr != 0 && eff[id_rs1_addr]) ||
              (id_uses_rs2 && id_rs2_addr != 0 && eff[id_rs2_addr]) ||
              (id_regWrite && id_rd_addr != 0 && eff[id_rd_addr]) ||
              (id_is_long && mout == MAXL));
        stl = (ldh || lgh) && !branch_taken;
        iss = id_valid && id_is_long && !stl && !branch_taken;
        nxt = branch_taken ? 0 : (lgh ? 2 : (ldh ? 1 : 0));

        s_pc = pc_write; s_exfl = id_ex_flush; s_iffl = if_id_flush;
        chk("pc_write",    32'(pc_write),    32'(!stl));
        chk("if_id_write", 32'(if_id_write), 32'(!stl));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(stl || branch_taken));
        chk("if_id_flush", 32'(if_id_flush), 32'(branch_taken));

        @(posedge clk);
        if (dok) begin
            mpend[long_rd] = 1'b0;
            mout--;
        end
        if (iss) begin
            if (id_regWrite && id_rd_addr != 0) mpend[id_rd_addr] = 1'b1;
            if (mout < MAXL) mout++;
        end
        mstate = nxt;
`ifdef HAZARD_STATS_EN
        if (stl) mcount = mcount + 32'd1;
`endif
        #1;
        chk("hz_state",    32'(hz_state), 32'(mstate));
        chk("pend_mask",   pend_mask,     model_mask());
        chk("stall_count", stall_count,   mcount);
    endtask

    // Asserts reset mid-cycle and checks that state clears without an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_pend_mask",   pend_mask,          32'h0);
        chk("rst_stall_count", stall_count,        32'h0);
        chk("rst_hz_state",    32'(hz_state),      32'h0);
        chk("rst_pc_write",    32'(pc_write),      32'h1);
        chk("rst_if_id_write", 32'(if_id_write),   32'h1);
        chk("rst_if_id_flush", 32'(if_id_flush),   32'(branch_taken));
        chk("rst_id_ex_flush", 32'(id_ex_flush),   32'(branch_taken));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw, lg;
        logic       exm;
        logic [4:0] exrd;
        logic       ld;
        logic [4:0] lrd;
        logic       br;
        logic       e_pc, e_exfl, e_iffl;
        logic [1:0] e_st;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[12];
    int   pq[$];

    initial begin
        // v  rs1 rs2 rd  u1 u2 rw lg exm exrd ld lrd br | pc exfl iffl st pend
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'b00, 32'h0};
        tbl[1]  = '{1, 5, 0, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0,   0, 1, 0, 2'b01, 32'h0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'b00, 32'h0};
        tbl[3]  = '{1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 2'b00, 32'h80};
        tbl[4]  = '{1, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'b10, 32'h80};
        tbl[5]  = '{1, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 2'b00, 32'h80};
        tbl[6]  = '{1, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0,   1, 0, 0, 2'b00, 32'h0};
        tbl[7]  = '{1, 5, 0, 0, 1, 0, 0, 0, 1, 5, 0, 0, 1,   1, 1, 1, 2'b00, 32'h0};
        tbl[8]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 2'b00, 32'h0};
        tbl[9]  = '{1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 2'b00, 32'h200};
        tbl[10] = '{1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 1, 9, 0,   1, 0, 0, 2'b00, 32'h200};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   1, 0, 0, 2'b00, 32'h0};

        set_idle();
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_pend_mask",   pend_mask,        32'h0);
        chk("init_hz_state",    32'(hz_state),    32'h0);
        chk("init_stall_count", stall_count,      32'h0);
        chk("init_pc_write",    32'(pc_write),    32'h1);
        rst = 1'b0;

        // ---------------- table-driven vectors
        for (int i = 0; i < 12; i++) begin
            id_valid = tbl[i].v;  id_rs1_addr = tbl[i].rs1; id_rs2_addr = tbl[i].rs2;
            id_rd_addr = tbl[i].rd; id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
            id_regWrite = tbl[i].rw; id_is_long = tbl[i].lg; ex_memRead = tbl[i].exm;
            ex_rd = tbl[i].exrd; long_done = tbl[i].ld; long_rd = tbl[i].lrd;
            branch_taken = tbl[i].br;
            do_cycle();
            chk($sformatf("tbl%0d_pc", i),    32'(s_pc),     32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_exfl", i),  32'(s_exfl),   32'(tbl[i].e_exfl));
            chk($sformatf("tbl%0d_iffl", i),  32'(s_iffl),   32'(tbl[i].e_iffl));
            chk($sformatf("tbl%0d_state", i), 32'(hz_state), 32'(tbl[i].e_st));
            chk($sformatf("tbl%0d_pend", i),  pend_mask,     tbl[i].e_pend);
        end
        set_idle();

        // ---------------- capacity limit: x1..x4 in flight, fifth waits
        for (int r = 1; r <= 4; r++) begin
            set_idle();
            id_valid = 1; id_is_long = 1; id_regWrite = 1; id_rd_addr = 5'(r);
            do_cycle();
        end
        chk("cap_pend", pend_mask, 32'h1E);
        set_idle();
        id_valid = 1; id_is_long = 1; id_regWrite = 1; id_rd_addr = 5'd10;
        do_cycle();
        chk("cap_stall_pc", 32'(s_pc), 32'h0);
        chk("cap_state",    32'(hz_state), 32'h2);
        long_done = 1; long_rd = 5'd1;
        do_cycle();
        chk("cap_done_still_stall", 32'(s_pc), 32'h0);
        long_done = 0;
        do_cycle();
        chk("cap_issue_pc", 32'(s_pc), 32'h1);
        chk("cap_issue_pend", pend_mask, 32'h41C);
        set_idle();
        foreach (pq[k]) pq.delete(k);
        pq = '{2, 3, 4, 10};
        foreach (pq[k]) begin
            long_done = 1; long_rd = 5'(pq[k]);
            do_cycle();
        end
        chk("cap_drained", pend_mask, 32'h0);
        set_idle();

        // ---------------- reset in the middle of a long op
        id_valid = 1; id_is_long = 1; id_regWrite = 1; id_rd_addr = 5'd7;
        do_cycle();
        set_idle();
        id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = 5'd7;
        do_cycle();
        chk("mid_pend_before_rst", pend_mask, 32'h80);
        do_reset();
        set_idle();
        long_done = 1; long_rd = 5'd7;   // stale writeback, must be ignored
        do_cycle();
        set_idle();
        for (int r = 11; r <= 15; r++) begin
            id_valid = 1; id_is_long = 1; id_regWrite = 1; id_rd_addr = 5'(r);
            do_cycle();
            if (r == 14) chk("post_rst_4th_issues", 32'(s_pc), 32'h1);
            if (r == 15) chk("post_rst_5th_stalls", 32'(s_pc), 32'h0);
        end
        set_idle();

        // ---------------- randomized against the model
        for (int n = 0; n < 3000; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1_addr  = 5'($urandom_range(0, 7));
            id_rs2_addr  = 5'($urandom_range(0, 7));
            id_rd_addr   = 5'($urandom_range(0, 7));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            id_regWrite  = ($urandom_range(0, 3) != 0);
            id_is_long   = ($urandom_range(0, 2) == 0);
            ex_memRead   = ($urandom_range(0, 2) == 0);
            ex_rd        = 5'($urandom_range(0, 7));
            branch_taken = ($urandom_range(0, 7) == 0);
            long_done    = ($urandom_range(0, 2) == 0);
            pq = {};
            for (int i = 1; i < 32; i++) if (mpend[i]) pq.push_back(i);
            if (pq.size() > 0 && $urandom_range(0, 1) == 1)
                long_rd = 5'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                long_rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            else do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
